// File: rtl/multimode_counter.sv
// multimode_counter: parametrised up/down counter with modulo limit, parallel
// load, clock prescaler and four terminal modes (wrap, saturate, one-shot,
// ping-pong). Emits a registered single-cycle terminal-count pulse.
//
// Handshake-free block: there is no valid/ready pair. The only strobe is
// 'load', which is sampled on every rising edge and wins over counting.
module multimode_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  dir,
  output logic                  running
);

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_PING = 2'b11;

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] pre_nxt;
  logic                  tick;
  logic                  up_term;
  logic                  dn_term;
  logic                  at_term;
  logic [WIDTH-1:0]      count_nxt;
  logic                  dir_nxt;
  logic                  running_nxt;
  logic                  tc_nxt;

  // Next-state logic: prescaler tick, terminal detection and per-mode step.
  always_comb begin
    tick        = en && (pre_cnt >= prescale);
    pre_nxt     = tick ? '0 : pre_cnt + 1'b1;
    up_term     = (count >= limit);
    dn_term     = (count == '0);
    at_term     = dir ? up_term : dn_term;
    count_nxt   = count;
    // Ping-pong owns its direction; other modes follow the up_dn pin.
    dir_nxt     = (mode == MODE_PING) ? dir : up_dn;
    running_nxt = running;
    tc_nxt      = 1'b0;
    // An expired one-shot ignores ticks until reloaded or reset.
    if (tick && running) begin
      if (!at_term) begin
        count_nxt = dir ? count + 1'b1 : count - 1'b1;
      end else begin
        tc_nxt = 1'b1;
        case (mode)
          MODE_WRAP: count_nxt = dir ? '0 : limit;
          MODE_SAT:  count_nxt = count;
          MODE_ONE:  running_nxt = 1'b0;
          MODE_PING: begin
            if (limit == '0) begin
              // Degenerate range: stay at zero, just bounce direction.
              count_nxt = '0;
              dir_nxt   = ~dir;
            end else if (dir) begin
              count_nxt = limit - 1'b1;
              dir_nxt   = 1'b0;
            end else begin
              count_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
              dir_nxt   = 1'b1;
            end
          end
          default: count_nxt = count;
        endcase
      end
    end
  end

  // State register: reset > load > tick; en gates only the prescaler/tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      dir     <= 1'b1;
      running <= 1'b1;
    end else if (load) begin
      count   <= load_val;
      pre_cnt <= '0;
      tc      <= 1'b0;
      dir     <= up_dn;
      running <= 1'b1;
    end else begin
      if (en) begin
        pre_cnt <= pre_nxt;
      end
      count   <= count_nxt;
      dir     <= dir_nxt;
      running <= running_nxt;
      tc      <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_multimode_counter.sv
// tb_multimode_counter: directed checks of multimode_counter against a
// behavioural reference plus hand-computed expectations.
module tb_multimode_counter;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;
  localparam int MODV       = 1 << WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic                  up_dn;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      limit;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  dir;
  logic                  running;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  // reference state
  int m_cnt;
  int m_pre;
  int m_dir;
  int m_run;
  int m_tc;

  multimode_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .mode(mode),
    .limit(limit), .load(load), .load_val(load_val), .prescale(prescale),
    .count(count), .tc(tc), .dir(dir), .running(running)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what the counter must do this edge, from the written rules.
  always @(posedge clk) begin
    int  nd;
    bit  tick;
    bit  term;
    if (!rst_n) begin
      m_cnt = 0; m_pre = 0; m_dir = 1; m_run = 1; m_tc = 0;
      check_en = 1'b1;
    end else if (load) begin
      m_cnt = int'(load_val); m_pre = 0; m_dir = int'(up_dn); m_run = 1; m_tc = 0;
    end else begin
      tick = 0;
      if (en) begin
        if (m_pre >= int'(prescale)) begin tick = 1; m_pre = 0; end
        else m_pre = m_pre + 1;
      end
      nd = (mode == 2'b11) ? m_dir : int'(up_dn);
      m_tc = 0;
      if (tick && m_run == 1) begin
        term = (m_dir == 1) ? (m_cnt >= int'(limit)) : (m_cnt == 0);
        if (!term) begin
          m_cnt = (m_dir == 1) ? (m_cnt + 1) % MODV : (m_cnt + MODV - 1) % MODV;
        end else begin
          m_tc = 1;
          case (mode)
            2'b00: m_cnt = (m_dir == 1) ? 0 : int'(limit);
            2'b01: ;
            2'b10: m_run = 0;
            default: begin
              if (limit == 0) begin m_cnt = 0; nd = 1 - m_dir; end
              else if (m_dir == 1) begin m_cnt = int'(limit) - 1; nd = 0; end
              else begin m_cnt = 1; nd = 1; end
            end
          endcase
        end
      end
      m_dir = nd;
    end
  end

  // Scoreboard compare: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (check_en) begin
      checks = checks + 1;
      if (int'(count) != m_cnt || int'(tc) != m_tc || int'(dir) != m_dir ||
          int'(running) != m_run) begin
        errors = errors + 1;
        $display("FAIL model t=%0t count=%0d/%0d tc=%0d/%0d dir=%0d/%0d running=%0d/%0d (got/required)",
                 $time, count, m_cnt, tc, m_tc, dir, m_dir, running, m_run);
      end
    end
  end

  // Hand-computed expectation; called right after a negedge.
  task automatic check_lit(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v, input bit d);
    load = 1'b1; load_val = WIDTH'(v); up_dn = d;
    cycles(1);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; mode = 2'b00; limit = 8'd255;
    load = 1'b0; load_val = '0; prescale = '0;
    cycles(2);
    check_lit("reset_count", int'(count), 0);
    check_lit("reset_tc", int'(tc), 0);
    check_lit("reset_dir", int'(dir), 1);
    check_lit("reset_running", int'(running), 1);

    // full-range wrap
    rst_n = 1'b1; en = 1'b1;
    cycles(255);
    check_lit("wrap_top", int'(count), 255);
    check_lit("wrap_top_tc", int'(tc), 0);
    cycles(1);
    check_lit("wrap_zero", int'(count), 0);
    check_lit("wrap_tc", int'(tc), 1);
    cycles(5);
    rst_n = 1'b0;
    cycles(1);
    check_lit("midrun_reset", int'(count), 0);
    check_lit("midrun_reset_tc", int'(tc), 0);

    // prescale and enable freeze
    rst_n = 1'b1; prescale = 4'd2; limit = 8'd9;
    cycles(2);
    check_lit("pre_hold", int'(count), 0);
    cycles(1);
    check_lit("pre_tick", int'(count), 1);
    cycles(1);
    en = 1'b0;
    cycles(5);
    check_lit("en_freeze", int'(count), 1);
    en = 1'b1;
    cycles(1);
    check_lit("resume_wait", int'(count), 1);
    cycles(1);
    check_lit("resume_tick", int'(count), 2);

    // down wrap then saturate
    prescale = '0; limit = 8'd5; mode = 2'b00;
    do_load(0, 1'b0);
    cycles(1);
    check_lit("down_wrap", int'(count), 5);
    check_lit("down_wrap_tc", int'(tc), 1);
    cycles(1);
    check_lit("down_step", int'(count), 4);
    mode = 2'b01;
    do_load(0, 1'b0);
    cycles(3);
    check_lit("sat_hold", int'(count), 0);
    check_lit("sat_tc", int'(tc), 1);

    // one-shot
    mode = 2'b10;
    do_load(3, 1'b0);
    cycles(3);
    check_lit("one_zero", int'(count), 0);
    check_lit("one_zero_tc", int'(tc), 0);
    cycles(1);
    check_lit("one_tc", int'(tc), 1);
    check_lit("one_expired", int'(running), 0);
    cycles(2);
    check_lit("one_idle_tc", int'(tc), 0);
    check_lit("one_idle_count", int'(count), 0);
    do_load(3, 1'b0);
    check_lit("one_rearm", int'(running), 1);
    cycles(1);
    check_lit("one_restart", int'(count), 2);

    // ping-pong
    mode = 2'b11; limit = 8'd3;
    do_load(0, 1'b1);
    cycles(4);
    check_lit("pp_rev_down", int'(count), 2);
    check_lit("pp_rev_dir", int'(dir), 0);
    check_lit("pp_rev_tc", int'(tc), 1);
    cycles(3);
    check_lit("pp_rev_up", int'(count), 1);
    check_lit("pp_rev_up_dir", int'(dir), 1);
    limit = 8'd0;
    cycles(1);
    check_lit("pp_lim0_a", int'(count), 0);
    check_lit("pp_lim0_dir_a", int'(dir), 0);
    cycles(1);
    check_lit("pp_lim0_dir_b", int'(dir), 1);

    // load beats a coincident tick; out-of-range wraps on next tick
    mode = 2'b00; limit = 8'd10; prescale = 4'd1;
    do_load(0, 1'b1);
    cycles(1);
    do_load(200, 1'b1);
    check_lit("load_prio", int'(count), 200);
    cycles(1);
    check_lit("load_pre_reset", int'(count), 200);
    cycles(1);
    check_lit("oor_wrap", int'(count), 0);
    check_lit("oor_tc", int'(tc), 1);

    // random sweep against the reference
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      up_dn    = $urandom_range(0, 1);
      mode     = 2'($urandom_range(0, 3));
      limit    = WIDTH'($urandom_range(0, 12));
      load     = ($urandom_range(0, 19) == 0);
      load_val = WIDTH'($urandom_range(0, 15));
      prescale = PRESCALE_W'($urandom_range(0, 2));
      rst_n    = ($urandom_range(0, 99) != 0);
      cycles(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
